// File: rtl/hazard_stall_ctrl.sv
// Stall/flush sequencing for the five-stage pipeline and arbitration of the shared refill port.
// Define HAZARD_PERF_CNT_EN to build the saturating refill-occupancy counter on o_refill_cycles.
module hazard_stall_ctrl (
  input  logic        i_clk,
  input  logic        i_arstn,
  input  logic        i_icache_miss,
  input  logic        i_dcache_miss,
  input  logic        i_mem_done,
  input  logic        i_load_use,
  input  logic        i_branch_mispred,
  output logic        o_mem_req,
  output logic        o_mem_req_src,
  output logic        o_stall_fetch,
  output logic        o_stall_dec,
  output logic        o_stall_exec,
  output logic        o_stall_mem,
  output logic        o_flush_dec,
  output logic        o_flush_exec,
  output logic        o_flush_wb,
  output logic [31:0] o_refill_cycles
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_D_REFILL = 2'd1,
    ST_I_REFILL = 2'd2
  } state_e;

  state_e state;
  state_e state_nxt;
  logic   memhold;

  // D-miss wins from IDLE since it belongs to the older instruction; an I-refill runs to completion
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (i_dcache_miss)      state_nxt = ST_D_REFILL;
        else if (i_icache_miss) state_nxt = ST_I_REFILL;
      end
      ST_D_REFILL: begin
        if (i_mem_done) state_nxt = i_icache_miss ? ST_I_REFILL : ST_IDLE;
      end
      ST_I_REFILL: begin
        if (i_mem_done) state_nxt = i_dcache_miss ? ST_D_REFILL : ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request flops follow the next state so a back-to-back handoff keeps o_mem_req high
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state         <= ST_IDLE;
      o_mem_req     <= 1'b0;
      o_mem_req_src <= 1'b0;
    end else begin
      state         <= state_nxt;
      o_mem_req     <= (state_nxt != ST_IDLE);
      o_mem_req_src <= (state_nxt == ST_D_REFILL);
    end
  end

  assign memhold = i_dcache_miss | (state == ST_D_REFILL);

  // Priority: memory hold, redirect, load-use, then fetch-side miss; all quiet while in reset
  always_comb begin
    o_stall_fetch = 1'b0;
    o_stall_dec   = 1'b0;
    o_stall_exec  = 1'b0;
    o_stall_mem   = 1'b0;
    o_flush_dec   = 1'b0;
    o_flush_exec  = 1'b0;
    o_flush_wb    = 1'b0;
    if (i_arstn) begin
      if (memhold) begin
        o_stall_fetch = 1'b1;
        o_stall_dec   = 1'b1;
        o_stall_exec  = 1'b1;
        o_stall_mem   = 1'b1;
        o_flush_wb    = 1'b1;
      end else if (i_branch_mispred) begin
        o_flush_dec  = 1'b1;
        o_flush_exec = 1'b1;
      end else if (i_load_use) begin
        o_stall_fetch = 1'b1;
        o_stall_dec   = 1'b1;
        o_flush_exec  = 1'b1;
      end else if (i_icache_miss || (state == ST_I_REFILL)) begin
        o_stall_fetch = 1'b1;
        o_flush_dec   = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] refill_cnt;

  // Saturating count of cycles with a refill outstanding
  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      refill_cnt <= '0;
    end else if ((state != ST_IDLE) && (refill_cnt != {CNT_W{1'b1}})) begin
      refill_cnt <= refill_cnt + CNT_W'(1);
    end
  end

  assign o_refill_cycles = refill_cnt;
`else
  assign o_refill_cycles = CNT_W'(0);
`endif

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline sequencing controller for the five-stage core. It generates per-stage stall and flush controls for the fetch, decode, execute, memory and writeback pipeline registers, and arbitrates the single shared refill port between I-cache and D-cache misses. Located in the core top beside the hazard/forwarding logic. Its `o_stall_mem` drives the stall input of the memory-stage pipeline register.

## Interface
- No parameters; all widths fixed.
- `i_clk` in 1: core clock, rising edge.
- `i_arstn` in 1: asynchronous active-low reset.
- `i_icache_miss` in 1: fetch-stage I-cache lookup missed (combinational from cache).
- `i_dcache_miss` in 1: memory-stage D-cache access missed (combinational from cache).
- `i_mem_done` in 1: one-cycle pulse, refill of current request complete.
- `i_load_use` in 1: decode-stage load-use hazard detected.
- `i_branch_mispred` in 1: execute-stage branch/jump redirect.
- `o_mem_req` out 1: refill request to memory port, registered.
- `o_mem_req_src` out 1: 0 = I-cache, 1 = D-cache; valid while `o_mem_req`.
- `o_stall_fetch`, `o_stall_dec`, `o_stall_exec`, `o_stall_mem` out 1 each: hold the corresponding pipeline register.
- `o_flush_dec`, `o_flush_exec`, `o_flush_wb` out 1 each: load a bubble into the corresponding register.
- `o_refill_cycles` out 32: cycles spent with a refill outstanding (see Configuration).

## Operation
- FSM states: IDLE, D_REFILL, I_REFILL.
- IDLE: on `i_dcache_miss` go to D_REFILL. Otherwise, on `i_icache_miss` go to I_REFILL. D-cache has priority because it holds the older instruction.
- D_REFILL: on `i_mem_done`, go to I_REFILL if `i_icache_miss`, else IDLE.
- I_REFILL: on `i_mem_done`, go to D_REFILL if `i_dcache_miss`, else IDLE. An I-refill is never preempted.
- `i_mem_done` is ignored in IDLE.
- `o_mem_req` = 1 in D_REFILL/I_REFILL. `o_mem_req_src` = 1 in D_REFILL, 0 otherwise.
- Combinational stall/flush, with `memhold = i_dcache_miss | state==D_REFILL`:
  - memhold: all four stalls = 1; `o_flush_wb` = 1; all other flushes = 0. Takes precedence over every rule below.
  - else `i_branch_mispred`: `o_flush_dec` = `o_flush_exec` = 1; no stalls. Fetch takes the redirect, even during I_REFILL.
  - else `i_load_use`: `o_stall_fetch` = `o_stall_dec` = 1; `o_flush_exec` = 1.
  - else (`i_icache_miss` or state==I_REFILL): `o_stall_fetch` = 1; `o_flush_dec` = 1. Older instructions drain.
- Mispredict during memhold is not lost: execute is frozen, so the source holds `i_branch_mispred` until memhold clears.
- A redirect during I_REFILL does not abort the refill. The fetch stall persists until `i_mem_done`.

## Timing
- Stall/flush outputs are combinational and valid in the same cycle as the miss/hazard inputs.
- `o_mem_req` rises on the edge after the miss is sampled. Minimum refill occupancy: 1 cycle of request before `i_mem_done` is accepted.
- `i_mem_done` sampled with `o_mem_req` = 1 ends the request on that edge. A back-to-back request (I then D, or D then I) keeps `o_mem_req` high with the source toggled on the same edge.
- Reset values: state IDLE; `o_mem_req` 0; `o_mem_req_src` 0; `o_refill_cycles` 0. While `i_arstn` = 0, every stall and flush output is forced to 0.
- Reset mid-refill: the FSM returns to IDLE immediately and the request drops asynchronously. A stale `i_mem_done` after reset is ignored.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `o_refill_cycles` increments on every cycle with state != IDLE.
  - Saturates at 0xFFFF_FFFF; no wrap.
  - Cleared only by reset.
- Not defined: `o_refill_cycles` is tied to 0 and no counter flops are generated.

## Test plan
- D-miss refill: `i_dcache_miss` = 1 at cycle 0, `i_mem_done` at cycle 5.
  - Cycle 0: all stalls = 1 and `o_flush_wb` = 1.
  - `o_mem_req` = 1 with src = 1 on cycles 1–5.
  - IDLE at cycle 6; `o_refill_cycles` = 5 with the macro.
- Simultaneous I- and D-miss at cycle 0, `i_mem_done` at cycles 3 and 7.
  - D-refill first; src 1 → 0 at the edge of cycle 3, with `o_mem_req` held high.
  - IDLE at cycle 8.
- D-miss during I_REFILL, arriving at cycle 2 of an I-refill done at cycle 4.
  - Stalls all 1 from cycle 2 onward.
  - D_REFILL entered at cycle 5, with no gap in `o_mem_req`.
- Load-use plus mispredict in the same cycle, IDLE:
  - `o_flush_dec` = `o_flush_exec` = 1, no stalls.
  - With load-use alone: `o_stall_fetch` = `o_stall_dec` = `o_flush_exec` = 1.
- Reset mid-refill: drop `i_arstn` at cycle 3 of a D_REFILL.
  - Same cycle: `o_mem_req` = 0 and all stalls = 0.
  - After release, an `i_mem_done` pulse leaves the FSM in IDLE.
- Counter saturation (macro defined): force the counter to 0xFFFF_FFFE, then run 3 refill cycles → reads 0xFFFF_FFFF.
